// File: rtl/bus_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : bus_req_queue
// Description : Client request FIFO feeding a one-command-at-a-time bus
//               master port. Writes are followed by a fixed idle gap; reads
//               wait for read data and hold a response until accepted.
//               Optional macro BUS_REQ_TIMEOUT_EN adds a read wait limit
//               (RD_TIMEOUT) that returns 8'hFF with rsp_err set.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_req_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WR_WAIT    = 40,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [15:0] rsp_addr,
  output logic        rsp_err,
  output logic        m_start,
  output logic        m_mode,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wr_data,
  input  logic [7:0]  m_rd_data,
  input  logic        m_wr_en
);

  localparam int unsigned c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w   = c_ptr_w + 1;
  // The wait counter is shared by the write gap and the optional read limit.
  localparam int unsigned c_cnt_max = (WR_WAIT > RD_TIMEOUT) ? WR_WAIT : RD_TIMEOUT;
  localparam int unsigned c_wait_w  = $clog2(c_cnt_max + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_WR = 3'd2,
    S_WAIT_RD = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [c_wait_w-1:0]  wait_q, wait_d;
  logic [c_ptr_w-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_cnt_w-1:0]   count_q;
  logic [24:0]          fifo_q [DEPTH];
  logic                 m_mode_q;
  logic [15:0]          m_addr_q;
  logic [7:0]           m_wdata_q;
  logic [7:0]           rsp_data_q;
  logic [15:0]          rsp_addr_q;
  logic                 w_push, w_pop, w_capture;
`ifdef BUS_REQ_TIMEOUT_EN
  logic                 w_timeout;
  logic                 rsp_err_q;
`endif

  assign req_ready = (count_q < c_cnt_w'(DEPTH));
  assign w_push    = req_valid && req_ready;
  // The head leaves the FIFO on the same edge the FSM moves to ISSUE.
  assign w_pop     = (state_q == S_IDLE) && (count_q != '0);

  assign m_start   = (state_q == S_ISSUE);
  assign m_mode    = m_mode_q;
  assign m_addr    = m_addr_q;
  assign m_wr_data = m_wdata_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
`ifdef BUS_REQ_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  // Next-state logic: sequencing of issue, wait and response phases
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    w_capture = 1'b0;
`ifdef BUS_REQ_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (w_pop) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = m_mode_q ? S_WAIT_WR : S_WAIT_RD;
      end
      S_WAIT_WR: begin
        if (wait_q == c_wait_w'(WR_WAIT - 1)) state_d = S_IDLE;
        else                                  wait_d  = wait_q + 1'b1;
      end
      S_WAIT_RD: begin
        // Real read data wins over a timeout landing on the same edge.
        if (m_wr_en) begin
          w_capture = 1'b1;
          state_d   = S_RESP;
        end
`ifdef BUS_REQ_TIMEOUT_EN
        else if (wait_q == c_wait_w'(RD_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          state_d   = S_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter, FIFO pointers/occupancy, command and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_mode_q   <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
`ifdef BUS_REQ_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (w_pop) begin
        {m_mode_q, m_addr_q, m_wdata_q} <= fifo_q[rd_ptr_q];
      end
      if (w_capture) begin
        rsp_data_q <= m_rd_data;
        rsp_addr_q <= m_addr_q;
`ifdef BUS_REQ_TIMEOUT_EN
        rsp_err_q  <= 1'b0;
`endif
      end
`ifdef BUS_REQ_TIMEOUT_EN
      if (w_timeout) begin
        rsp_data_q <= 8'hFF;
        rsp_addr_q <= m_addr_q;
        rsp_err_q  <= 1'b1;
      end
`endif
    end
  end

  // FIFO storage; entries are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= {req_mode, req_addr, req_wdata};
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_req_queue.sv
`default_nettype none
module tb_bus_req_queue;

  localparam int DEPTH      = 4;
  localparam int WR_WAIT    = 10;
  localparam int RD_TIMEOUT = 20;
  localparam int BIG        = 1 << 30;
`ifdef BUS_REQ_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct packed {
    logic        mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_mode = 1'b0, rsp_ready = 1'b0, m_wr_en = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0, m_rd_data = '0;
  logic        req_ready, rsp_valid, rsp_err, m_start, m_mode;
  logic [7:0]  rsp_data, m_wr_data;
  logic [15:0] rsp_addr, m_addr;

  bus_req_queue #(.DEPTH(DEPTH), .WR_WAIT(WR_WAIT), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .m_start(m_start), .m_mode(m_mode), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_wr_en(m_wr_en)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: queue contents plus the timeline of the one command in flight
  req_t fifo[$];
  req_t script[$];
  req_t cur, prev_req;
  bit   prev_push, prev_idle, have_cur, in_rd, resp_active, rdy_drv, from_script;
  int   prev_size, cyc, idle_at, issue_cyc, rd_fire, rsp_at, rsp_rel_at;
  int   force_dly = 0, force_hold = -1, push_pct = 0, spur_pct = 0;
  bit   force_a5 = 1'b0;
  logic [7:0] exp_rdata;
  bit   exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo.delete();
    script.delete();
    prev_push = 0; prev_idle = 1; prev_size = 0; have_cur = 0;
    in_rd = 0; resp_active = 0; rdy_drv = 0;
    idle_at = 0; rd_fire = -1; rsp_at = BIG; issue_cyc = 0;
  endtask

  function automatic bit busy();
    return (fifo.size() > 0) || (cyc < idle_at) || resp_active;
  endfunction

  // One clock cycle: check DUT against the model at this sample, then drive the next cycle.
  task automatic step();
    bit exp_start;
    int dly;
    exp_start = prev_idle && (prev_size > 0);
    if (prev_push) fifo.push_back(prev_req);
    if (resp_active && rdy_drv) begin
      resp_active = 0;
      idle_at     = cyc;
    end
    chk("m_start", m_start, exp_start);
    if (exp_start) begin
      cur       = fifo.pop_front();
      have_cur  = 1;
      issue_cyc = cyc;
      if (cur.mode) begin
        idle_at = cyc + WR_WAIT + 1;
      end else begin
        idle_at = BIG;
        in_rd   = 1;
        dly     = (force_dly > 0) ? force_dly : $urandom_range(1, 25);
        force_dly = 0;
        if (TMO && dly > RD_TIMEOUT) begin
          rd_fire   = -1;
          rsp_at    = cyc + RD_TIMEOUT + 1;
          exp_rdata = 8'hFF;
          exp_err   = 1;
        end else begin
          rd_fire   = cyc + dly;
          rsp_at    = cyc + dly + 1;
          exp_rdata = force_a5 ? 8'hA5 : 8'($urandom);
          exp_err   = 0;
        end
        force_a5 = 0;
      end
    end
    if (have_cur && cyc < idle_at) chk("cmd_fields", {m_mode, m_addr, m_wr_data}, cur);
    if (in_rd && cyc >= rsp_at) in_rd = 0;
    if (cyc == rsp_at) begin
      resp_active = 1;
      rsp_rel_at  = cyc + ((force_hold >= 0) ? force_hold : $urandom_range(0, 4));
      force_hold  = -1;
    end
    chk("rsp_valid", rsp_valid, resp_active);
    if (resp_active) chk("rsp_fields", {rsp_data, rsp_addr, rsp_err}, {exp_rdata, cur.addr, exp_err});
`ifndef BUS_REQ_TIMEOUT_EN
    chk("rsp_err_zero", rsp_err, 1'b0);
`endif
    chk("req_ready", req_ready, fifo.size() < DEPTH);
    prev_size = fifo.size();
    prev_idle = (cyc >= idle_at);

    // client side
    if (script.size() > 0) begin
      req_valid = 1'b1;
      {req_mode, req_addr, req_wdata} = script[0];
      from_script = 1;
    end else begin
      req_valid = ($urandom_range(0, 99) < push_pct);
      req_mode  = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      from_script = 0;
    end
    prev_push = req_valid && (fifo.size() < DEPTH);
    prev_req  = {req_mode, req_addr, req_wdata};
    if (prev_push && from_script) void'(script.pop_front());
    // master side: quiet during a read wait except the data strobe, noisy elsewhere
    if (in_rd && cyc > issue_cyc) begin
      m_wr_en   = (cyc == rd_fire);
      m_rd_data = (cyc == rd_fire) ? exp_rdata : 8'($urandom);
    end else begin
      m_wr_en   = ($urandom_range(0, 99) < spur_pct);
      m_rd_data = 8'($urandom);
    end
    if (resp_active) rsp_ready = (cyc >= rsp_rel_at);
    else             rsp_ready = 1'($urandom);
    rdy_drv = resp_active && rsp_ready;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    model_reset();
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m_start, m_mode, m_addr, m_wr_data, rsp_valid, rsp_data, rsp_addr, rsp_err}, '0);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed opening: write 1234/A5, then read 1234 answered after 30 cycles, response held 10 cycles
    script.push_back('{mode: 1'b1, addr: 16'h1234, wdata: 8'hA5});
    script.push_back('{mode: 1'b0, addr: 16'h1234, wdata: 8'h00});
    force_dly = 30; force_a5 = 1; force_hold = 10;
    push_pct = 90; spur_pct = 20;
    for (int i = 0; i < 200; i++) step();
    push_pct = 25;
    for (int i = 0; i < 300; i++) step();

    // Drain so the reset scenario starts from an empty, idle queue
    push_pct = 0;
    for (int i = 0; i < 600 && busy(); i++) step();
    chk("drain_done", busy(), 1'b0);

    // Read stuck in its wait with three requests queued behind it, then reset
    script.push_back('{mode: 1'b0, addr: 16'hBEEF, wdata: 8'h11});
    script.push_back('{mode: 1'b1, addr: 16'h0001, wdata: 8'h22});
    script.push_back('{mode: 1'b0, addr: 16'h0002, wdata: 8'h33});
    script.push_back('{mode: 1'b1, addr: 16'h0003, wdata: 8'h44});
    force_dly = 1000;
    for (int i = 0; i < 6; i++) step();
    chk("queued_before_reset", fifo.size(), 3);
    req_valid = 1'b0; m_wr_en = 1'b0; rsp_ready = 1'b0;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", {m_start, m_mode, m_addr, m_wr_data, rsp_valid, rsp_data, rsp_addr, rsp_err}, '0);
    chk("async_reset_ready", req_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    model_reset();
    force_dly = 0;
    @(posedge clk);
    #1;
    cyc++;
    chk("ready_after_release", req_ready, 1'b1);
    spur_pct = 50;
    for (int i = 0; i < 60; i++) step();

    // Normal traffic resumes after reset
    push_pct = 40; spur_pct = 20;
    for (int i = 0; i < 250; i++) step();
    push_pct = 0;
    for (int i = 0; i < 600 && busy(); i++) step();
    chk("final_drain", busy(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
